input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Conditions raw board switch and button inputs before they reach the combinational full-adder stage, which consumes `sw_db` as its operand bits.
- Per bit: a 2-flop synchronizer, then a saturating stability counter, then a registered debounced level.
- Also produces a one-cycle rising-edge pulse per button for downstream event logic.

Parameters:
- N_SW, 4, number of switch inputs.
- N_BTN, 4, number of button inputs.
- DB_CYCLES, 16, consecutive cycles a synchronized input must differ from its debounced value before the debounced value flips; legal range 2..2^CNT_W-1.
- CNT_W, 16, width of each per-bit stability counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  N_SW  raw switch levels; asynchronous to clk.
- btn  input  N_BTN  raw button levels; asynchronous to clk.
- sw_db  output  N_SW  debounced switch levels.
- btn_db  output  N_BTN  debounced button levels.
- btn_press  output  N_BTN  one-cycle pulse on each debounced button 0->1 transition.

Behaviour:
- Reset (rst_n=0, asynchronous assert) clears:
  - both synchronizer stages of every bit;
  - all counters;
  - sw_db, btn_db and btn_press, all to 0.
- Release is synchronous in effect: first update on the first rising clk edge with rst_n=1.
- Synchronizer: s1 <= raw, s2 <= s1, every cycle, every bit. Only s2 feeds the debounce logic.
- Per-bit debounce, evaluated every edge with s2 and db sampled before the edge:
  - s2 == db: counter <= 0; db holds.
  - s2 != db and counter < DB_CYCLES-1: counter <= counter+1; db holds.
  - s2 != db and counter == DB_CYCLES-1: db <= s2; counter <= 0.
- Switch and button bits use identical, independent logic; no cross-bit interaction.
- Latency:
  - Call the first edge after the raw input settles edge 0.
  - db changes at edge DB_CYCLES+1, provided raw stays stable throughout.
  - Example: DB_CYCLES=4 gives a change at edge 5.
- Glitch rejection: any cycle with s2 == db clears the counter. Pulses shorter than DB_CYCLES cycles at s2 never reach db.
- Counter never exceeds DB_CYCLES-1; no wrap-around.
- btn_press:
  - btn_press[i] <= 1 on exactly the edge where btn_db[i] goes 0->1; 0 on every other edge.
  - It is therefore high in the same cycle btn_db[i] first reads 1, for exactly one cycle.
  - No pulse on 1->0 transitions.
  - Back-to-back pulses are impossible because DB_CYCLES >= 2.
- Simultaneous flips on several bits are each handled independently in the same cycle.
- Reset mid-count: the counter and db are cleared immediately. After release, an input held at 1 is re-debounced from scratch: db rises at edge DB_CYCLES+1 after release, with a btn_press pulse.

Test Plan:
- Reset then idle, DB_CYCLES=4:
  - Hold rst_n=0 with sw=4'hF -> sw_db=0, btn_db=0, btn_press=0 throughout reset.
  - Release -> sw_db=4'hF exactly at edge 5 after release.
- Clean press, DB_CYCLES=4: btn=4'b0001 set before edge 0 -> btn_db[0]=1 and btn_press=4'b0001 after edge 5; btn_press=0 after edge 6.
- Bounce rejection, DB_CYCLES=4: sw[2] toggles 1,0,1,0 every 3 cycles, then holds 1 -> sw_db[2] stays 0 during bouncing and rises exactly 5 edges after the final 0->1.
- Release path, DB_CYCLES=4: btn[3] 1->0 after a debounced press -> btn_db[3] falls at edge 5; btn_press[3] never asserts.
- Independence: sw=4'b1010 and btn=4'b0110 applied on the same cycle -> sw_db=4'b1010, btn_db=4'b0110 and btn_press=4'b0110 on the same edge, for one cycle.
- Async reset mid-count, DB_CYCLES=16: assert rst_n=0 for 1 ns between edges at count 10 -> outputs are 0 immediately. With the input still high, sw_db rises 17 edges after release.

Source files
------------

// File: rtl/input_debouncer.sv
// Synchronizes and debounces raw switch/button levels; db flips DB_CYCLES+1 edges after a stable change.
// Free-running, no backpressure; btn_press is a registered one-cycle pulse on each debounced button rise.
module input_debouncer #(
  parameter int N_SW      = 4,
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  sw,
  input  logic [N_BTN-1:0] btn,
  output logic [N_SW-1:0]  sw_db,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_press
);

  localparam int N = N_SW + N_BTN;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(DB_CYCLES - 1);

  // Switches occupy the low bits, buttons the high bits; every bit is debounced independently.
  logic [N-1:0]     raw;
  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  logic [N-1:0]     db;
  logic [N-1:0]     db_nxt;
  logic [CNT_W-1:0] cnt     [N];
  logic [CNT_W-1:0] cnt_nxt [N];

  assign raw = {btn, sw};

  always_comb begin
    db_nxt = db;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != db[i]) begin
        if (cnt[i] == LIM) begin
          db_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      db        <= '0;
      btn_press <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1        <= raw;
      s2        <= s1;
      db        <= db_nxt;
      btn_press <= db_nxt[N-1:N_SW] & ~db[N-1:N_SW];
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign sw_db  = db[N_SW-1:0];
  assign btn_db = db[N-1:N_SW];

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench: one DB_CYCLES=4 instance for function/latency, one DB_CYCLES=16 instance for async reset mid-count.
module tb_input_debouncer;

  logic       clk;
  logic       rst_n;
  logic       rst16_n;
  logic [3:0] sw, btn, sw16, btn16;
  logic [3:0] sw_db, btn_db, btn_press;
  logic [3:0] sw_db16, btn_db16, btn_press16;

  int checks = 0;
  int errors = 0;

  input_debouncer #(.N_SW(4), .N_BTN(4), .DB_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn),
    .sw_db(sw_db), .btn_db(btn_db), .btn_press(btn_press)
  );

  input_debouncer #(.N_SW(4), .N_BTN(4), .DB_CYCLES(16), .CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst16_n), .sw(sw16), .btn(btn16),
    .sw_db(sw_db16), .btn_db(btn_db16), .btn_press(btn_press16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; leave time 1 ns past the last edge for sampling and driving.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    rst16_n = 1'b1;
    sw      = 4'hF;
    btn     = 4'h0;
    sw16    = 4'h0;
    btn16   = 4'h0;
    #1;
    rst_n   = 1'b0;
    rst16_n = 1'b0;

    // Reset holds everything low even with switches high
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("rst_sw_db", 32'(sw_db), 32'h0);
      chk("rst_btn_db", 32'(btn_db), 32'h0);
      chk("rst_btn_press", 32'(btn_press), 32'h0);
    end

    // Release: first edge afterwards is edge 0, sw_db rises at edge 5
    rst_n = 1'b1;
    tick(5);
    chk("idle_sw_db_e4", 32'(sw_db), 32'h0);
    tick(1);
    chk("idle_sw_db_e5", 32'(sw_db), 32'hF);

    // Clean press on btn[0]
    btn = 4'b0001;
    tick(5);
    chk("press_btn_db_e4", 32'(btn_db), 32'h0);
    chk("press_pulse_e4", 32'(btn_press), 32'h0);
    tick(1);
    chk("press_btn_db_e5", 32'(btn_db), 32'h1);
    chk("press_pulse_e5", 32'(btn_press), 32'h1);
    tick(1);
    chk("press_pulse_e6", 32'(btn_press), 32'h0);
    chk("press_btn_db_e6", 32'(btn_db), 32'h1);

    // btn[3] rises while btn[0] falls: only the rise pulses
    btn = 4'b1000;
    tick(6);
    chk("swap_btn_db_e5", 32'(btn_db), 32'h8);
    chk("swap_pulse_e5", 32'(btn_press), 32'h8);

    // Release path on btn[3]: falls at edge 5, never pulses
    btn = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      chk("rel_pulse", 32'(btn_press), 32'h0);
      if (k == 4) chk("rel_btn_db_e4", 32'(btn_db), 32'h8);
      if (k == 5) chk("rel_btn_db_e5", 32'(btn_db), 32'h0);
    end

    // Drop all switches so sw[2] can be bounced from 0
    sw = 4'h0;
    tick(6);
    chk("sw_clear", 32'(sw_db), 32'h0);

    // Bounce sw[2] in 3-cycle pulses; never long enough to flip
    for (int p = 0; p < 4; p++) begin
      sw = (p % 2 == 0) ? 4'b0100 : 4'b0000;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        chk("bounce_sw_db", 32'(sw_db), 32'h0);
      end
    end
    sw = 4'b0100;
    tick(5);
    chk("bounce_final_e4", 32'(sw_db), 32'h0);
    tick(1);
    chk("bounce_final_e5", 32'(sw_db), 32'h4);

    // Simultaneous multi-bit flips on both groups
    sw  = 4'b1010;
    btn = 4'b0110;
    tick(5);
    chk("indep_sw_db_e4", 32'(sw_db), 32'h4);
    chk("indep_pulse_e4", 32'(btn_press), 32'h0);
    tick(1);
    chk("indep_sw_db_e5", 32'(sw_db), 32'hA);
    chk("indep_btn_db_e5", 32'(btn_db), 32'h6);
    chk("indep_pulse_e5", 32'(btn_press), 32'h6);
    tick(1);
    chk("indep_pulse_e6", 32'(btn_press), 32'h0);
    chk("indep_btn_db_e6", 32'(btn_db), 32'h6);

    // DB_CYCLES=16: debounce btn16[1] high first (flip at edge 17)
    rst16_n = 1'b1;
    btn16   = 4'b0010;
    tick(17);
    chk("d16_btn_db_e16", 32'(btn_db16), 32'h0);
    tick(1);
    chk("d16_btn_db_e17", 32'(btn_db16), 32'h2);
    chk("d16_pulse_e17", 32'(btn_press16), 32'h2);

    // sw16[0] rises; counter reaches 10 after edge 11, then a 1 ns reset between edges
    sw16 = 4'b0001;
    tick(12);
    #2;
    rst16_n = 1'b0;
    #1;
    chk("d16_async_sw_db", 32'(sw_db16), 32'h0);
    chk("d16_async_btn_db", 32'(btn_db16), 32'h0);
    chk("d16_async_pulse", 32'(btn_press16), 32'h0);
    rst16_n = 1'b1;
    tick(17);
    chk("d16_rel_sw_db_e16", 32'(sw_db16), 32'h0);
    chk("d16_rel_btn_db_e16", 32'(btn_db16), 32'h0);
    tick(1);
    chk("d16_rel_sw_db_e17", 32'(sw_db16), 32'h1);
    chk("d16_rel_btn_db_e17", 32'(btn_db16), 32'h2);
    chk("d16_rel_pulse_e17", 32'(btn_press16), 32'h2);
    tick(1);
    chk("d16_rel_pulse_e18", 32'(btn_press16), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
